q_agent_ctrl: RTL

Parametrised successor to the fixed 6-bit-state / 4-action Q-learning agent. It holds its own Q-table and runs the full step sequence itself: accept transition, scan the next-state row, pick an epsilon-greedy action, apply the TD update to the previous pair, emit the action. It sits between the environment model and the host, with valid/ready handshakes on both sides. It replaces the free-running delay registers with an explicit step state machine.

---
 rtl/q_agent_pkg.sv | 34 +++
 rtl/q_agent_lfsr.sv | 37 +++
 rtl/q_agent_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q_agent_pkg.sv
// q_agent_pkg: shared types and helpers for the q_agent_ctrl Q-learning agent.
// Holds the step state encoding, the LFSR feedback mask and signed saturation.
package q_agent_pkg;

  // Step sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    UPD  = 2'd2,
    EMIT = 2'd3
  } step_state_t;

  // Right-shifting Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Clamp a signed value into the signed range of the given width (width <= 31).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    logic signed [31:0] res_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) begin
      res_v = max_v;
    end else if (value < min_v) begin
      res_v = min_v;
    end else begin
      res_v = value;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/q_agent_lfsr.sv
// q_agent_lfsr: free-running 16-bit Galois LFSR used as the exploration source.
// Advances once per clock; the seed must be nonzero.
module q_agent_lfsr
  import q_agent_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_r;
  logic [15:0] lfsr_next_s;

  // Next value: shift right, fold the feedback mask in when bit 0 falls out.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[15:1]};
    if (lfsr_r[0]) begin
      lfsr_next_s = lfsr_next_s ^ LFSR_POLY;
    end else begin
      lfsr_next_s = lfsr_next_s;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= lfsr_next_s;
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: rtl/q_agent_ctrl.sv
// q_agent_ctrl: self-contained epsilon-greedy Q-learning agent with its own Q-table.
// Each accepted transition runs SCAN (row max/argmax), UPD (TD write to the
// previous pair) and EMIT (action handshake) before accepting the next one.
// Build option: define Q_AGENT_EPS_DECAY_EN to decay the exploration threshold
// on every terminal transition, with the epsilon port acting as the floor.
module q_agent_ctrl
  import q_agent_pkg::*;
#(
  parameter int          S_W             = 6,
  parameter int          ACT_W           = 2,
  parameter int          Q_W             = 16,
  parameter int          ALPHA_SHIFT     = 2,
  parameter int          GAMMA_SHIFT     = 1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          EPS_DECAY_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  env_valid,
  output logic                  env_ready,
  input  logic [S_W-1:0]        next_state,
  input  logic signed [Q_W-1:0] reward,
  input  logic                  done,
  input  logic [15:0]           epsilon,
  output logic                  action_valid,
  input  logic                  action_ready,
  output logic [ACT_W-1:0]      action,
  output logic                  upd_valid,
  output logic [S_W-1:0]        upd_state,
  output logic [ACT_W-1:0]      upd_action,
  output logic signed [Q_W-1:0] upd_value
);

  localparam int N_ACT = 1 << ACT_W;
  localparam int ROWS  = 1 << S_W;
  localparam int EXT_W = Q_W + 2;
  localparam logic signed [Q_W-1:0] Q_MOST_NEG = {1'b1, {(Q_W-1){1'b0}}};
  localparam logic [ACT_W-1:0]      IDX_LAST   = ACT_W'(N_ACT - 1);

  // Sequencer and step context.
  step_state_t             state_r;
  logic [ACT_W-1:0]        idx_r;
  logic signed [Q_W-1:0]   max_r;
  logic [ACT_W-1:0]        argmax_r;
  logic [S_W-1:0]          s_lat_r;
  logic signed [Q_W-1:0]   r_lat_r;
  logic                    done_lat_r;
  logic                    explore_r;
  logic [ACT_W-1:0]        rand_a_r;
  logic                    first_r;
  logic [S_W-1:0]          prev_s_r;
  logic [ACT_W-1:0]        prev_a_r;

  // Registered outputs.
  logic                    env_ready_r;
  logic                    action_valid_r;
  logic [ACT_W-1:0]        action_r;
  logic                    upd_valid_r;
  logic [S_W-1:0]          upd_state_r;
  logic [ACT_W-1:0]        upd_action_r;
  logic signed [Q_W-1:0]   upd_value_r;

  // Q-table storage.
  logic signed [Q_W-1:0]   q_tab_r [ROWS][N_ACT];

  // Datapath nets.
  logic [15:0]             lfsr_s;
  logic [15:0]             eps_eff_s;
  logic                    accept_s;
  logic                    wr_en_s;
  logic signed [Q_W-1:0]   scan_val_s;
  logic signed [Q_W-1:0]   old_q_s;
  logic signed [EXT_W-1:0] max_ext_s;
  logic signed [EXT_W-1:0] old_ext_s;
  logic signed [EXT_W-1:0] rew_ext_s;
  logic signed [EXT_W-1:0] target_ext_s;
  logic signed [EXT_W-1:0] diff_ext_s;
  logic signed [EXT_W-1:0] sum_ext_s;
  logic signed [Q_W-1:0]   new_q_s;
  logic [ACT_W-1:0]        act_choice_s;

  q_agent_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr_s)
  );

`ifdef Q_AGENT_EPS_DECAY_EN
  logic [15:0] eps_q_r;
  logic [15:0] eps_dec_s;
  logic [15:0] eps_floor_s;

  // Effective threshold is the decayed value, never below the port minimum.
  always_comb begin
    if (eps_q_r < epsilon) begin
      eps_eff_s = epsilon;
    end else begin
      eps_eff_s = eps_q_r;
    end
    eps_dec_s = eps_eff_s - (eps_eff_s >> EPS_DECAY_SHIFT);
    if (eps_dec_s < epsilon) begin
      eps_floor_s = epsilon;
    end else begin
      eps_floor_s = eps_dec_s;
    end
  end

  // Decay the threshold once per accepted terminal transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eps_q_r <= 16'hFFFF;
    end else if (accept_s && done) begin
      eps_q_r <= eps_floor_s;
    end else begin
      eps_q_r <= eps_q_r;
    end
  end
`else
  assign eps_eff_s = epsilon;
`endif

  assign accept_s = (state_r == IDLE) && env_valid && env_ready_r;
  assign wr_en_s  = (state_r == UPD) && !first_r;

  // TD target, update and saturation in Q_W+2 bits; action selection.
  always_comb begin
    scan_val_s = q_tab_r[s_lat_r][idx_r];
    old_q_s    = q_tab_r[prev_s_r][prev_a_r];
    max_ext_s  = {{2{max_r[Q_W-1]}}, max_r};
    old_ext_s  = {{2{old_q_s[Q_W-1]}}, old_q_s};
    rew_ext_s  = {{2{r_lat_r[Q_W-1]}}, r_lat_r};
    if (done_lat_r) begin
      target_ext_s = rew_ext_s;
    end else begin
      target_ext_s = rew_ext_s + (max_ext_s >>> GAMMA_SHIFT);
    end
    diff_ext_s = target_ext_s - old_ext_s;
    sum_ext_s  = old_ext_s + (diff_ext_s >>> ALPHA_SHIFT);
    new_q_s    = Q_W'(sat_signed({{(32-EXT_W){sum_ext_s[EXT_W-1]}}, sum_ext_s}, Q_W));
    if (explore_r) begin
      act_choice_s = rand_a_r;
    end else begin
      act_choice_s = argmax_r;
    end
  end

  // Q-table: cleared on reset, single write port driven in UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int a = 0; a < N_ACT; a++) begin
          q_tab_r[r][a] <= '0;
        end
      end
    end else if (wr_en_s) begin
      q_tab_r[prev_s_r][prev_a_r] <= new_q_s;
    end
  end

  // Step state machine with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      max_r          <= Q_MOST_NEG;
      argmax_r       <= '0;
      s_lat_r        <= '0;
      r_lat_r        <= '0;
      done_lat_r     <= 1'b0;
      explore_r      <= 1'b0;
      rand_a_r       <= '0;
      first_r        <= 1'b1;
      prev_s_r       <= '0;
      prev_a_r       <= '0;
      env_ready_r    <= 1'b1;
      action_valid_r <= 1'b0;
      action_r       <= '0;
      upd_valid_r    <= 1'b0;
      upd_state_r    <= '0;
      upd_action_r   <= '0;
      upd_value_r    <= '0;
    end else begin
      upd_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            s_lat_r     <= next_state;
            r_lat_r     <= reward;
            done_lat_r  <= done;
            explore_r   <= (lfsr_s < eps_eff_s);
            rand_a_r    <= lfsr_s[ACT_W-1:0];
            idx_r       <= '0;
            max_r       <= Q_MOST_NEG;
            argmax_r    <= '0;
            env_ready_r <= 1'b0;
            state_r     <= SCAN;
          end else begin
            env_ready_r <= 1'b1;
          end
        end
        SCAN: begin
          // Strictly-greater keeps the lowest index on ties.
          if (scan_val_s > max_r) begin
            max_r    <= scan_val_s;
            argmax_r <= idx_r;
          end
          idx_r <= idx_r + ACT_W'(1);
          if (idx_r == IDX_LAST) begin
            state_r <= UPD;
          end
        end
        UPD: begin
          if (!first_r) begin
            upd_valid_r  <= 1'b1;
            upd_state_r  <= prev_s_r;
            upd_action_r <= prev_a_r;
            upd_value_r  <= new_q_s;
          end
          action_r       <= act_choice_s;
          action_valid_r <= 1'b1;
          prev_s_r       <= s_lat_r;
          prev_a_r       <= act_choice_s;
          first_r        <= done_lat_r;
          state_r        <= EMIT;
        end
        EMIT: begin
          if (action_ready) begin
            action_valid_r <= 1'b0;
            env_ready_r    <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          action_valid_r <= 1'b0;
          env_ready_r    <= 1'b1;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign env_ready    = env_ready_r;
  assign action_valid = action_valid_r;
  assign action       = action_r;
  assign upd_valid    = upd_valid_r;
  assign upd_state    = upd_state_r;
  assign upd_action   = upd_action_r;
  assign upd_value    = upd_value_r;

endmodule
